line_write_buffer: RTL

- Write-combining buffer between the datapath's word-wide store port and the line-wide memory/L2 write port.
- Scatters 16-bit store words (3-bit word offset, per-byte enables) into one 128-bit line register.
- Emits the assembled line with a per-byte mask over a valid/ready handshake.
- It is the write-side counterpart of the 8:1 word-select path used on line reads.

---
 rtl/line_write_buffer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/line_write_buffer.sv
// -----------------------------------------------------------------------------
// line_write_buffer
//
// Write-combining buffer that sits between the word-wide store port and the
// line-wide memory/L2 write port. Store words (16 bits, 3-bit word offset,
// per-byte enables) are scattered into one 128-bit line register along with a
// per-byte valid mask. The assembled line is offered downstream over a
// valid/ready handshake. This is the write-side counterpart of the 8:1
// word-select path used on line reads.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid        store word offered
//   in_ready        buffer can take the store this cycle (combinational)
//   in_line_addr    line address of the store (byte address [15:4])
//   in_offset       word index within the line; word k is bits [16k+15:16k]
//   in_wmask        byte enables, bit0 = low byte, bit1 = high byte
//   in_data         store data
//   flush           request drain of the held line
//   out_valid       assembled line offered downstream
//   out_ready       downstream accepts the line
//   out_addr        line address of the held line
//   out_line        line data
//   out_mask        per-byte valid mask; bit 2k+b is byte b of word k
//   busy            high whenever a line is held (FILLING or DRAIN)
// -----------------------------------------------------------------------------
module line_write_buffer #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH-1:0]   in_line_addr,
  input  logic [2:0]              in_offset,
  input  logic [1:0]              in_wmask,
  input  logic [WORD_WIDTH-1:0]   in_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_WIDTH-1:0]   out_addr,
  output logic [8*WORD_WIDTH-1:0] out_line,
  output logic [15:0]             out_mask,
  output logic                    busy
);

  localparam int LINE_WIDTH = 8 * WORD_WIDTH;

  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] FILLING = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] line_q;
  logic [15:0]           mask_q;

  logic                  addr_match;
  logic                  accept;
  logic                  conflict;
  logic [LINE_WIDTH-1:0] line_next;
  logic [15:0]           mask_next;

  assign addr_match = (in_line_addr == addr_q);

  // A store to a different line while FILLING is refused; the held line is
  // drained first and the store is retried against an empty buffer.
  assign in_ready = (state == EMPTY) || ((state == FILLING) && addr_match);
  assign conflict = (state == FILLING) && in_valid && !addr_match;

  // A zero byte-enable store is handshaken but is a no-op.
  assign accept   = in_valid && in_ready && (in_wmask != 2'b00);

  // Byte scatter: each enabled byte lands at line byte 2*offset+b.
  // NOTE: every variable assigned in always_comb gets a default first, so a
  // path that skips an assignment cannot infer a latch.
  always_comb begin
    line_next = line_q;
    mask_next = mask_q;
    if (accept) begin
      for (int k = 0; k < 8; k++) begin
        for (int b = 0; b < 2; b++) begin
          if (in_offset == 3'(k) && in_wmask[b]) begin
            line_next[(2*k+b)*8 +: 8] = in_data[b*8 +: 8];
            mask_next[2*k+b]          = 1'b1;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      addr_q <= '0;
      line_q <= '0;
      mask_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            addr_q <= in_line_addr;
            line_q <= line_next;
            mask_q <= mask_next;
            state  <= flush ? DRAIN : FILLING;
          end
        end
        FILLING: begin
          if (accept) begin
            line_q <= line_next;
            mask_q <= mask_next;
          end
          // A matching store in the same cycle is merged before draining.
          if (conflict || flush || (&mask_next)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            line_q <= '0;
            mask_q <= '0;
            state  <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_valid = (state == DRAIN);
  assign busy      = (state != EMPTY);
  assign out_addr  = addr_q;
  assign out_line  = line_q;
  assign out_mask  = mask_q;

endmodule
